// File: rtl/float_checker_if.sv
// Handshake/bus bundle between a float stimulus/result source and float_checker.
interface float_checker_if #(
    parameter int unsigned W = 64
);
    logic          i_ExpValid;
    logic [W-1:0]  iv_ExpFlt;
    logic          o_ExpReady;
    logic          i_ResValid;
    logic [W-1:0]  iv_ResFlt;
    logic          i_ClrStats;
    logic          o_CmpValid;
    logic          o_Mismatch;
    logic [2:0]    ov_ErrFlags;
    logic [31:0]   ov_CmpCount;
    logic [31:0]   ov_ErrCount;

    modport master (
        output i_ExpValid, iv_ExpFlt, i_ResValid, iv_ResFlt, i_ClrStats,
        input  o_ExpReady, o_CmpValid, o_Mismatch, ov_ErrFlags, ov_CmpCount, ov_ErrCount
    );

    modport slave (
        input  i_ExpValid, iv_ExpFlt, i_ResValid, iv_ResFlt, i_ClrStats,
        output o_ExpReady, o_CmpValid, o_Mismatch, ov_ErrFlags, ov_CmpCount, ov_ErrCount
    );
endinterface

// File: rtl/float_checker.sv
// Queues expected floats and compares each DUT result against the oldest one (NaN/zero aware).
// Define FLOAT_CHECKER_ULP_TOL_EN to accept results within pTolUlp ULPs; otherwise bitwise equality.
module float_checker #(
    parameter int unsigned pPrecision = 2,
    parameter int unsigned pWidthExp  = 8,
    parameter int unsigned pWidthMan  = 23,
    parameter int unsigned pDepth     = 16,
    parameter int unsigned pTolUlp    = 0
) (
    input logic            i_Clk,
    input logic            i_ARstN,
    float_checker_if.slave bus
);
    localparam int unsigned pExpW = (pPrecision == 1) ? 8  : (pPrecision == 2) ? 11 : pWidthExp;
    localparam int unsigned pManW = (pPrecision == 1) ? 23 : (pPrecision == 2) ? 52 : pWidthMan;
    localparam int unsigned W     = pExpW + pManW + 1;
    localparam int unsigned MW    = pExpW + pManW;
    localparam int unsigned AW    = $clog2(pDepth);
    localparam logic [AW:0] FULL  = (AW+1)'(pDepth);

    logic [W-1:0]  mem [pDepth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic          exp_ready;
    logic          cmp_valid, mismatch;
    logic [2:0]    err_flags, err_flags_n;
    logic [31:0]   cmp_count, cmp_count_n, err_count, err_count_n;

    logic          push_c, drop_c, pop_c, under_c, mismatch_c, mag_ok_c;
    logic [W-1:0]  exp_flt, res_flt;
    logic [MW-1:0] mag_e, mag_r;
    logic          nan_e, nan_r, zero_e, zero_r;

    // Readiness comes only from registered occupancy, so a pop never frees room for a same-cycle push.
    assign push_c  = bus.i_ExpValid && exp_ready;
    assign drop_c  = bus.i_ExpValid && !exp_ready;
    assign pop_c   = bus.i_ResValid && (count != '0);
    assign under_c = bus.i_ResValid && (count == '0);
    assign count_n = count + (AW+1)'(push_c) - (AW+1)'(pop_c);

    assign exp_flt = mem[rd_ptr];
    assign res_flt = bus.iv_ResFlt;
    assign mag_e   = exp_flt[MW-1:0];
    assign mag_r   = res_flt[MW-1:0];
    assign nan_e   = (&exp_flt[W-2 -: pExpW]) && (|exp_flt[pManW-1:0]);
    assign nan_r   = (&res_flt[W-2 -: pExpW]) && (|res_flt[pManW-1:0]);
    assign zero_e  = (mag_e == '0);
    assign zero_r  = (mag_r == '0);

`ifdef FLOAT_CHECKER_ULP_TOL_EN
    logic [MW-1:0] ulp_dist_c;
    assign ulp_dist_c = (mag_e >= mag_r) ? (mag_e - mag_r) : (mag_r - mag_e);
    assign mag_ok_c   = (ulp_dist_c <= MW'(pTolUlp));
`else
    assign mag_ok_c   = (mag_e == mag_r);
`endif

    // Classification priority: NaN, signed zero, sign, magnitude.
    always_comb begin
        mismatch_c = 1'b0;
        if (nan_e || nan_r)                 mismatch_c = !(nan_e && nan_r);
        else if (zero_e && zero_r)          mismatch_c = 1'b0;
        else if (exp_flt[W-1] != res_flt[W-1]) mismatch_c = 1'b1;
        else                                mismatch_c = !mag_ok_c;
    end

    // Clear is applied first so this cycle's events still land in the fresh stats.
    always_comb begin
        err_flags_n = bus.i_ClrStats ? 3'b000 : err_flags;
        cmp_count_n = bus.i_ClrStats ? 32'd0  : cmp_count;
        err_count_n = bus.i_ClrStats ? 32'd0  : err_count;
        err_flags_n = err_flags_n | {under_c, drop_c, pop_c && mismatch_c};
        if (pop_c && (cmp_count_n != 32'hFFFF_FFFF))
            cmp_count_n = cmp_count_n + 32'd1;
        if (pop_c && mismatch_c && (err_count_n != 32'hFFFF_FFFF))
            err_count_n = err_count_n + 32'd1;
    end

    always_ff @(posedge i_Clk or negedge i_ARstN) begin
        if (!i_ARstN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            exp_ready <= 1'b1;
            cmp_valid <= 1'b0;
            mismatch  <= 1'b0;
            err_flags <= 3'b000;
            cmp_count <= 32'd0;
            err_count <= 32'd0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_n;
            exp_ready <= (count_n != FULL);
            cmp_valid <= pop_c;
            mismatch  <= pop_c && mismatch_c;
            err_flags <= err_flags_n;
            cmp_count <= cmp_count_n;
            err_count <= err_count_n;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_Clk) begin
        if (push_c) mem[wr_ptr] <= bus.iv_ExpFlt;
    end

    assign bus.o_ExpReady  = exp_ready;
    assign bus.o_CmpValid  = cmp_valid;
    assign bus.o_Mismatch  = mismatch;
    assign bus.ov_ErrFlags = err_flags;
    assign bus.ov_CmpCount = cmp_count;
    assign bus.ov_ErrCount = err_count;
endmodule

// File: tb/tb_float_checker.sv
// Scoreboard bench for float_checker in single precision, depth 4, tolerance 1 ULP when enabled.
module tb_float_checker;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
`ifdef FLOAT_CHECKER_ULP_TOL_EN
    localparam int unsigned TOL = 1;
`else
    localparam int unsigned TOL = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_checker_if #(.W(W)) bus ();

    float_checker #(
        .pPrecision(1), .pWidthExp(8), .pWidthMan(23), .pDepth(DEPTH), .pTolUlp(1)
    ) dut (
        .i_Clk(clk), .i_ARstN(rst_n), .bus(bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mfifo[$];
    bit          sb[$];
    logic [31:0] m_cmp = 0, m_err = 0;
    logic [2:0]  m_flags = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit ref_mismatch(input logic [31:0] a, input logic [31:0] b);
        bit na, nb;
        logic [30:0] d;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na || nb) return !(na && nb);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31]) return 1'b1;
        d = (a[30:0] > b[30:0]) ? a[30:0] - b[30:0] : b[30:0] - a[30:0];
        return d > TOL;
    endfunction

    // Monitor: every compare pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        bit e;
        if (rst_n && bus.o_CmpValid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cmp actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("mismatch", 32'(bus.o_Mismatch), 32'(e));
            end
        end
    end

    task automatic cycle(input bit dp, input logic [31:0] pv, input bit dr, input logic [31:0] rv,
                         input bit clr);
        int pre;
        logic [31:0] e;
        bit mm;
        pre = mfifo.size();
        bus.i_ExpValid = dp; bus.iv_ExpFlt = pv;
        bus.i_ResValid = dr; bus.iv_ResFlt = rv;
        bus.i_ClrStats = clr;
        if (clr) begin m_cmp = 0; m_err = 0; m_flags = 0; end
        if (dr) begin
            if (pre > 0) begin
                e  = mfifo.pop_front();
                mm = ref_mismatch(e, rv);
                sb.push_back(mm);
                if (m_cmp != 32'hFFFF_FFFF) m_cmp++;
                if (mm) begin
                    if (m_err != 32'hFFFF_FFFF) m_err++;
                    m_flags[0] = 1'b1;
                end
            end else m_flags[2] = 1'b1;
        end
        if (dp) begin
            if (pre < DEPTH) mfifo.push_back(pv);
            else m_flags[1] = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_ExpValid = 0; bus.i_ResValid = 0; bus.i_ClrStats = 0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [31:0] v);   cycle(1, v, 0, 0, 0); endtask
    task automatic result(input logic [31:0] v); cycle(0, 0, 1, v, 0); endtask

    task automatic check_stats(input string tag);
        idle();
        check({tag, "_drain"}, 32'(sb.size()), 0);
        check({tag, "_ready"}, 32'(bus.o_ExpReady), 32'(mfifo.size() < DEPTH));
        check({tag, "_cmpcnt"}, bus.ov_CmpCount, m_cmp);
        check({tag, "_errcnt"}, bus.ov_ErrCount, m_err);
        check({tag, "_flags"}, 32'(bus.ov_ErrFlags), 32'(m_flags));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_ExpValid = 0; bus.iv_ExpFlt = 0; bus.i_ResValid = 0; bus.iv_ResFlt = 0; bus.i_ClrStats = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.o_ExpReady), 1);
        check("rst_cmpvalid", 32'(bus.o_CmpValid), 0);
        check("rst_cmpcnt", bus.ov_CmpCount, 0);
        check("rst_errcnt", bus.ov_ErrCount, 0);
        check("rst_flags", 32'(bus.ov_ErrFlags), 0);
        rst_n = 1'b1;
        idle();

        push(32'h3F80_0000); result(32'h3F80_0000);
        check("first_cmpvalid", 32'(bus.o_CmpValid), 1);
        check("first_cmpcnt", bus.ov_CmpCount, 1);
        check_stats("exact");

        push(32'h3F80_0000); result(32'h3F80_0001);
        push(32'h3F80_0000); result(32'h3F80_0002);
        check_stats("ulp");

        push(32'h7FC0_0000); result(32'hFFC0_0001);
        push(32'h8000_0000); result(32'h0000_0000);
        push(32'h3F80_0000); result(32'h7FC0_0000);
        check_stats("special");

        push(32'h3F80_0000); result(32'hBF80_0000);
        push(32'h3F80_0001); result(32'h3F80_0000);
        push(32'h7F80_0000); result(32'h7F80_0000);
        push(32'h7F80_0000); result(32'hFF80_0000);
        check_stats("misc");

        cycle(0, 0, 0, 0, 1);
        check_stats("clr1");

        push(32'h4000_0000); push(32'h4040_0000); push(32'h4080_0000); push(32'h40A0_0000);
        check("full_ready", 32'(bus.o_ExpReady), 0);
        push(32'h4100_0000);
        cycle(1, 32'h4110_0000, 1, 32'h4000_0000, 0);
        check_stats("full");
        result(32'h4040_0000); result(32'h4080_0001); result(32'h40A0_0000);
        check_stats("drain");

        result(32'h3F80_0000);
        check_stats("under");
        cycle(0, 0, 0, 0, 1);
        check_stats("clr2");

        push(32'h3F80_0000);
        cycle(0, 0, 1, 32'hBF80_0000, 1);
        check_stats("clr_cmp");

        push(32'h3F80_0000);
        bus.i_ResValid = 1; bus.iv_ResFlt = 32'h3F80_0000;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_cmpvalid", 32'(bus.o_CmpValid), 0);
        @(posedge clk); #1;
        bus.i_ResValid = 0;
        repeat (2) idle();
        mfifo.delete(); sb.delete();
        m_cmp = 0; m_err = 0; m_flags = 0;
        rst_n = 1'b1;
        repeat (3) idle();
        check_stats("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
